// File: rtl/adc_meas_avg_pkg.sv
// Shared definitions for the ADC measurement/averaging front-end:
// FSM state encodings, default geometry and a small clamp helper.
package adc_meas_avg_pkg;

    localparam int CADC_WIDTH_DEF    = 10;
    localparam int LOG2_NAVG_MAX_DEF = 4;
    localparam int TIMEOUT_WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACQ  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } meas_state_e;

    // Limit a requested log2 sample count to the supported maximum.
    function automatic logic [2:0] clamp_log2(input logic [2:0] req, input logic [2:0] lim);
        logic [2:0] res;
        if (req > lim) begin
            res = lim;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/adc_sample_acc.sv
// Running sum plus min/max tracker for one measurement run.
// clr restarts the run (min at all-ones, max at zero); sample_en folds in one sample.
module adc_sample_acc
    import adc_meas_avg_pkg::*;
#(
    parameter int SAMPLE_WIDTH = CADC_WIDTH_DEF,
    parameter int ACC_WIDTH    = CADC_WIDTH_DEF + LOG2_NAVG_MAX_DEF
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    clr,
    input  logic                    sample_en,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [ACC_WIDTH-1:0]    acc,
    output logic [SAMPLE_WIDTH-1:0] min_val,
    output logic [SAMPLE_WIDTH-1:0] max_val
);

    logic [ACC_WIDTH-1:0]    acc_r;
    logic [SAMPLE_WIDTH-1:0] min_r;
    logic [SAMPLE_WIDTH-1:0] max_r;

    // Accumulate samples and track extremes; clear has priority over a sample.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            acc_r <= {ACC_WIDTH{1'b0}};
            min_r <= {SAMPLE_WIDTH{1'b1}};
            max_r <= {SAMPLE_WIDTH{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_WIDTH{1'b0}};
            min_r <= {SAMPLE_WIDTH{1'b1}};
            max_r <= {SAMPLE_WIDTH{1'b0}};
        end else if (sample_en) begin
            acc_r <= acc_r + {{(ACC_WIDTH-SAMPLE_WIDTH){1'b0}}, sample};
            if (sample < min_r) begin
                min_r <= sample;
            end
            if (sample > max_r) begin
                max_r <= sample;
            end
        end
    end

    assign acc     = acc_r;
    assign min_val = min_r;
    assign max_val = max_r;

endmodule

// File: rtl/adc_meas_avg.sv
// ADC measurement front-end: on START, collects 2^NAVG_LOG2 samples (one per
// ADC_RDY rising edge), then publishes rounded average, min and max with a
// level done flag. An inter-sample timeout ends a stalled run with an error.
module adc_meas_avg
    import adc_meas_avg_pkg::*;
#(
    parameter int CADC_WIDTH    = CADC_WIDTH_DEF,
    parameter int LOG2_NAVG_MAX = LOG2_NAVG_MAX_DEF,
    parameter int TIMEOUT_WIDTH = TIMEOUT_WIDTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     START,
    input  logic [2:0]               NAVG_LOG2,
    input  logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYC,
    input  logic [CADC_WIDTH-1:0]    ADC,
    input  logic                     ADC_RDY,
    output logic [CADC_WIDTH-1:0]    AVG_OUT,
    output logic [CADC_WIDTH-1:0]    MIN_OUT,
    output logic [CADC_WIDTH-1:0]    MAX_OUT,
    output logic                     MEAS_BUSY,
    output logic                     MEAS_DONE,
    output logic                     TIMEOUT_ERR
);

    localparam int ACC_W = CADC_WIDTH + LOG2_NAVG_MAX;
    localparam int CNT_W = LOG2_NAVG_MAX + 1;

    meas_state_e              state_r, next_state_s;
    logic                     rdy_prev_r;
    logic                     strobe_s;
    logic [2:0]               log2n_r;
    logic [CNT_W-1:0]         count_r, count_inc_s, n_s;
    logic [TIMEOUT_WIDTH-1:0] timer_r, timeout_limit_s;
    logic                     timeout_armed_s;
    logic [ACC_W-1:0]         acc_s;
    logic [CADC_WIDTH-1:0]    min_s, max_s;
    logic [ACC_W:0]           sum_s, quot_s;
    logic [CADC_WIDTH-1:0]    avg_s;
    logic                     start_run_s, sample_en_s, timeout_s, div_s;
    logic [CADC_WIDTH-1:0]    avg_r, min_r, max_r;
    logic                     busy_r, done_r, terr_r;

    assign strobe_s        = ADC_RDY & ~rdy_prev_r;
    assign n_s             = {{(CNT_W-1){1'b0}}, 1'b1} << log2n_r;
    assign count_inc_s     = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign timeout_armed_s = (TIMEOUT_CYC != {TIMEOUT_WIDTH{1'b0}});
    assign timeout_limit_s = TIMEOUT_CYC - {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    assign sum_s           = {1'b0, acc_s} + {{(ACC_W+1-CNT_W){1'b0}}, (n_s >> 1)};
    assign quot_s          = sum_s >> log2n_r;

    adc_sample_acc #(
        .SAMPLE_WIDTH (CADC_WIDTH),
        .ACC_WIDTH    (ACC_W)
    ) u_acc (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clr       (start_run_s),
        .sample_en (sample_en_s),
        .sample    (ADC),
        .acc       (acc_s),
        .min_val   (min_s),
        .max_val   (max_s)
    );

    // Saturate the rounded quotient to the sample range.
    always_comb begin
        avg_s = quot_s[CADC_WIDTH-1:0];
        if (quot_s > {{(LOG2_NAVG_MAX+1){1'b0}}, {CADC_WIDTH{1'b1}}}) begin
            avg_s = {CADC_WIDTH{1'b1}};
        end else begin
            avg_s = quot_s[CADC_WIDTH-1:0];
        end
    end

    // Next-state and one-cycle control strobes; START low aborts any active run.
    always_comb begin
        next_state_s = state_r;
        start_run_s  = 1'b0;
        sample_en_s  = 1'b0;
        timeout_s    = 1'b0;
        div_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    next_state_s = ST_ACQ;
                    start_run_s  = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACQ: begin
                if (!START) begin
                    next_state_s = ST_IDLE;
                end else if (strobe_s) begin
                    sample_en_s = 1'b1;
                    if (count_inc_s == n_s) begin
                        next_state_s = ST_DIV;
                    end else begin
                        next_state_s = ST_ACQ;
                    end
                end else if (timeout_armed_s && (timer_r == timeout_limit_s)) begin
                    next_state_s = ST_DONE;
                    timeout_s    = 1'b1;
                end else begin
                    next_state_s = ST_ACQ;
                end
            end
            ST_DIV: begin
                if (!START) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                    div_s        = 1'b1;
                end
            end
            ST_DONE: begin
                if (!START) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and ADC_RDY edge-detect history.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            rdy_prev_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            rdy_prev_r <= ADC_RDY;
        end
    end

    // Run bookkeeping: latched sample count, samples taken, idle-cycle timer.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            log2n_r <= 3'd0;
            count_r <= {CNT_W{1'b0}};
            timer_r <= {TIMEOUT_WIDTH{1'b0}};
        end else if (start_run_s) begin
            log2n_r <= clamp_log2(NAVG_LOG2, 3'(LOG2_NAVG_MAX));
            count_r <= {CNT_W{1'b0}};
            timer_r <= {TIMEOUT_WIDTH{1'b0}};
        end else if (sample_en_s) begin
            count_r <= count_inc_s;
            timer_r <= {TIMEOUT_WIDTH{1'b0}};
        end else if (state_r == ST_ACQ) begin
            timer_r <= timer_r + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Registered result and status outputs; results change only on DIV or timeout.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            avg_r  <= {CADC_WIDTH{1'b0}};
            min_r  <= {CADC_WIDTH{1'b0}};
            max_r  <= {CADC_WIDTH{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            terr_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_ACQ) || (next_state_s == ST_DIV);
            done_r <= (next_state_s == ST_DONE);
            if (start_run_s) begin
                terr_r <= 1'b0;
            end else if (timeout_s) begin
                terr_r <= 1'b1;
            end
            if (timeout_s) begin
                avg_r <= {CADC_WIDTH{1'b0}};
                if (count_r == {CNT_W{1'b0}}) begin
                    min_r <= {CADC_WIDTH{1'b0}};
                    max_r <= {CADC_WIDTH{1'b0}};
                end else begin
                    min_r <= min_s;
                    max_r <= max_s;
                end
            end else if (div_s) begin
                avg_r <= avg_s;
                min_r <= min_s;
                max_r <= max_s;
            end
        end
    end

    assign AVG_OUT     = avg_r;
    assign MIN_OUT     = min_r;
    assign MAX_OUT     = max_r;
    assign MEAS_BUSY   = busy_r;
    assign MEAS_DONE   = done_r;
    assign TIMEOUT_ERR = terr_r;

endmodule
